idu1_scoreboard: RTL and testbench

IDU1_SCOREBOARD -- requirements
Module: idu1_scoreboard

---
 rtl/idu1_scoreboard_if.sv | 47 ++++
 rtl/idu1_scoreboard.sv | 197 +++++++++++++++++++
 tb/tb_idu1_scoreboard.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/idu1_scoreboard_if.sv
// ----------------------------------------------------------------------------
// idu1_scoreboard_if
// Handshake bundle around the issue scoreboard.
//   Decode -> scoreboard : in_valid/in_ready, operand and destination
//                          addresses/enables, opaque decode payload.
//   Scoreboard -> EXU    : out_valid/out_ready, captured operand data,
//                          destination address/enable, payload.
// Modports:
//   master : the decode/EXU side (drives in_* request fields and out_ready)
//   slave  : the scoreboard (drives in_ready and the registered out_* fields)
// ----------------------------------------------------------------------------
interface idu1_scoreboard_if #(
    parameter int XLEN      = 32,
    parameter int PAYLOAD_W = 64
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic [4:0]           in_rs1_addr;
    logic [4:0]           in_rs2_addr;
    logic [4:0]           in_rd_addr;
    logic                 in_rs1_en;
    logic                 in_rs2_en;
    logic                 in_rd_en;
    logic [PAYLOAD_W-1:0] in_payload;

    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      out_rs1_data;
    logic [XLEN-1:0]      out_rs2_data;
    logic [4:0]           out_rd_addr;
    logic                 out_rd_en;
    logic [PAYLOAD_W-1:0] out_payload;

    modport master (
        output in_valid, in_rs1_addr, in_rs2_addr, in_rd_addr,
               in_rs1_en, in_rs2_en, in_rd_en, in_payload, out_ready,
        input  in_ready, out_valid, out_rs1_data, out_rs2_data,
               out_rd_addr, out_rd_en, out_payload
    );

    modport slave (
        input  in_valid, in_rs1_addr, in_rs2_addr, in_rd_addr,
               in_rs1_en, in_rs2_en, in_rd_en, in_payload, out_ready,
        output in_ready, out_valid, out_rs1_data, out_rs2_data,
               out_rd_addr, out_rd_en, out_payload
    );
endinterface

// File: rtl/idu1_scoreboard.sv
// ----------------------------------------------------------------------------
// idu1_scoreboard
// Issue stage with register file and per-register pending-write counters.
// An instruction from decode is accepted only when none of its sources has an
// outstanding write that is not being resolved this cycle and its destination
// has not reached the outstanding-write limit. Accepted instructions capture
// their operands (with same-cycle writeback bypass) and are presented to the
// execution unit one cycle later from registers.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   bus (slave)       : decode-side request and EXU-side issue handshake
//   flush             : kill the held instruction, block acceptance this cycle
//   wb_valid/rd/data  : NUM_WB writeback ports, port i in slice i
//   hazard_stall_cnt  : saturating count of hazard-stall cycles
//   sb_err            : sticky pending-counter underflow flag
// ----------------------------------------------------------------------------
module idu1_scoreboard #(
    parameter int              XLEN                     = 32,
    parameter int              NUM_WB                   = 2,
    parameter int              MAX_PEND                 = 3,
    parameter int              PAYLOAD_W                = 64,
    parameter logic [XLEN-1:0] STACK_POINTER_INIT_VALUE = XLEN'(32'h80000000)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    idu1_scoreboard_if.slave       bus,
    input  logic                   flush,
    input  logic [NUM_WB-1:0]      wb_valid,
    input  logic [NUM_WB*5-1:0]    wb_rd_addr,
    input  logic [NUM_WB*XLEN-1:0] wb_data,
    output logic [31:0]            hazard_stall_cnt,
    output logic                   sb_err
);
    localparam int CW  = $clog2(MAX_PEND + 1);
    localparam int WCW = $clog2(NUM_WB + 1);

    logic [XLEN-1:0]      rf_q   [32];
    logic [CW-1:0]        pend_q [32];
    logic [CW-1:0]        pend_d [32];
    logic [WCW-1:0]       wbCnt  [32];
    logic [XLEN-1:0]      wbVal  [32];

    logic                 outValid_q;
    logic [XLEN-1:0]      outRs1_q;
    logic [XLEN-1:0]      outRs2_q;
    logic [4:0]           outRdAddr_q;
    logic                 outRdEn_q;
    logic [PAYLOAD_W-1:0] outPayload_q;
    logic [31:0]          stallCnt_q;
    logic                 sbErr_q;

    logic                 rs1Haz, rs2Haz, rdHaz, hazard;
    logic                 slotFree, accept, issued, killHeld, stallEvent;
    logic                 underflow;
    logic [XLEN-1:0]      opnd1, opnd2;
    int                   net;

    // Per-register view of this cycle's writebacks: how many ports hit each
    // register, and the value that lands (higher port index overrides).
    always_comb begin
        for (int r = 0; r < 32; r++) begin
            wbCnt[r] = '0;
            wbVal[r] = '0;
            for (int i = 0; i < NUM_WB; i++) begin
                if (wb_valid[i] && wb_rd_addr[i*5 +: 5] == 5'(r)) begin
                    wbCnt[r] = wbCnt[r] + WCW'(1);
                    wbVal[r] = wb_data[i*XLEN +: XLEN];
                end
            end
        end
    end

    // A source with a single pending write can go if that write retires now;
    // the value is then taken from the bypass below.
    always_comb begin
        rs1Haz = bus.in_rs1_en && (bus.in_rs1_addr != 5'd0) &&
                 ((pend_q[bus.in_rs1_addr] > CW'(1)) ||
                  ((pend_q[bus.in_rs1_addr] == CW'(1)) && (wbCnt[bus.in_rs1_addr] == '0)));
        rs2Haz = bus.in_rs2_en && (bus.in_rs2_addr != 5'd0) &&
                 ((pend_q[bus.in_rs2_addr] > CW'(1)) ||
                  ((pend_q[bus.in_rs2_addr] == CW'(1)) && (wbCnt[bus.in_rs2_addr] == '0)));
        rdHaz  = bus.in_rd_en && (bus.in_rd_addr != 5'd0) &&
                 (pend_q[bus.in_rd_addr] == CW'(MAX_PEND)) &&
                 (wbCnt[bus.in_rd_addr] == '0);
        hazard = rs1Haz | rs2Haz | rdHaz;
    end

    // The held instruction is killed by flush only if it is not leaving this
    // cycle; its reserved destination slot is then given back.
    assign slotFree     = ~outValid_q | bus.out_ready;
    assign bus.in_ready = slotFree & ~hazard & ~flush;
    assign accept       = bus.in_valid & bus.in_ready;
    assign issued       = outValid_q & bus.out_ready;
    assign killHeld     = flush & outValid_q & ~issued & outRdEn_q & (outRdAddr_q != 5'd0);
    assign stallEvent   = bus.in_valid & ~flush & slotFree & hazard;

    // Pending counters net increment, writeback retirements and kill together;
    // a negative result clamps to zero and is reported as an underflow.
    always_comb begin
        underflow = 1'b0;
        net       = 0;
        pend_d[0] = '0;
        for (int r = 1; r < 32; r++) begin
            net = int'(pend_q[r])
                + int'(accept && bus.in_rd_en && (bus.in_rd_addr == 5'(r)))
                - int'(wbCnt[r])
                - int'(killHeld && (outRdAddr_q == 5'(r)));
            if (net < 0) begin
                pend_d[r] = '0;
                underflow = 1'b1;
            end else begin
                pend_d[r] = CW'(net);
            end
        end
    end

    // Operand capture sees a same-cycle writeback before the register file does.
    always_comb begin
        opnd1 = '0;
        opnd2 = '0;
        if (bus.in_rs1_addr != 5'd0) begin
            opnd1 = (wbCnt[bus.in_rs1_addr] != '0) ? wbVal[bus.in_rs1_addr] : rf_q[bus.in_rs1_addr];
        end
        if (bus.in_rs2_addr != 5'd0) begin
            opnd2 = (wbCnt[bus.in_rs2_addr] != '0) ? wbVal[bus.in_rs2_addr] : rf_q[bus.in_rs2_addr];
        end
    end

    // Register file: x0 is never written, x2 comes out of reset as the stack pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 32; r++) begin
                rf_q[r] <= (r == 2) ? STACK_POINTER_INIT_VALUE : '0;
            end
        end else begin
            for (int r = 1; r < 32; r++) begin
                if (wbCnt[r] != '0) begin
                    rf_q[r] <= wbVal[r];
                end
            end
        end
    end

    // Pending counters and the sticky underflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 32; r++) begin
                pend_q[r] <= '0;
            end
            sbErr_q <= 1'b0;
        end else begin
            for (int r = 0; r < 32; r++) begin
                pend_q[r] <= pend_d[r];
            end
            sbErr_q <= sbErr_q | underflow;
        end
    end

    // Issue register: loads on accept, holds until issued or flushed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outValid_q   <= 1'b0;
            outRs1_q     <= '0;
            outRs2_q     <= '0;
            outRdAddr_q  <= '0;
            outRdEn_q    <= 1'b0;
            outPayload_q <= '0;
        end else if (accept) begin
            outValid_q   <= 1'b1;
            outRs1_q     <= opnd1;
            outRs2_q     <= opnd2;
            outRdAddr_q  <= bus.in_rd_addr;
            outRdEn_q    <= bus.in_rd_en;
            outPayload_q <= bus.in_payload;
        end else if (flush || issued) begin
            outValid_q   <= 1'b0;
        end
    end

    // Hazard stall counter, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCnt_q <= '0;
        end else if (stallEvent && (stallCnt_q != 32'hFFFF_FFFF)) begin
            stallCnt_q <= stallCnt_q + 32'd1;
        end
    end

    assign bus.out_valid    = outValid_q;
    assign bus.out_rs1_data = outRs1_q;
    assign bus.out_rs2_data = outRs2_q;
    assign bus.out_rd_addr  = outRdAddr_q;
    assign bus.out_rd_en    = outRdEn_q;
    assign bus.out_payload  = outPayload_q;
    assign hazard_stall_cnt = stallCnt_q;
    assign sb_err           = sbErr_q;
endmodule

// File: tb/tb_idu1_scoreboard.sv
// ----------------------------------------------------------------------------
// tb_idu1_scoreboard
// Directed scenarios plus randomized traffic for idu1_scoreboard, checked
// against a reference model that tracks outstanding writes per register as
// plain integers and the architectural register values as an array.
// ----------------------------------------------------------------------------
module tb_idu1_scoreboard;
    localparam int XLEN      = 32;
    localparam int NUM_WB    = 2;
    localparam int MAX_PEND  = 3;
    localparam int PAYLOAD_W = 64;

    logic                   clk;
    logic                   rst_n;
    logic                   flush;
    logic [NUM_WB-1:0]      wb_valid;
    logic [NUM_WB*5-1:0]    wb_rd_addr;
    logic [NUM_WB*XLEN-1:0] wb_data;
    logic [31:0]            hazard_stall_cnt;
    logic                   sb_err;

    int checks = 0;
    int errors = 0;

    idu1_scoreboard_if #(.XLEN(XLEN), .PAYLOAD_W(PAYLOAD_W)) bus ();

    idu1_scoreboard #(
        .XLEN(XLEN), .NUM_WB(NUM_WB), .MAX_PEND(MAX_PEND), .PAYLOAD_W(PAYLOAD_W),
        .STACK_POINTER_INIT_VALUE(32'h80000000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .flush(flush),
        .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
        .hazard_stall_cnt(hazard_stall_cnt), .sb_err(sb_err)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference state: outstanding writes per register, architectural values,
    // the instruction currently offered to the EXU, stall count, error flag.
    int          mPend [32];
    logic [31:0] mRf   [32];
    logic        mOutValid;
    logic [31:0] mOut1, mOut2;
    logic [4:0]  mOutRd;
    logic        mOutRdEn;
    logic [63:0] mOutPay;
    logic [31:0] mStall;
    logic        mErr;
    logic        mReady;

    task automatic modelReset();
        for (int r = 0; r < 32; r++) begin
            mPend[r] = 0;
            mRf[r]   = (r == 2) ? 32'h80000000 : 32'h0;
        end
        mOutValid = 1'b0; mOut1 = '0; mOut2 = '0; mOutRd = '0; mOutRdEn = 1'b0;
        mOutPay = '0; mStall = '0; mErr = 1'b0;
    endtask

    function automatic int hits(input logic [4:0] a);
        int n = 0;
        for (int i = 0; i < NUM_WB; i++) if (wb_valid[i] && wb_rd_addr[i*5 +: 5] == a) n++;
        return n;
    endfunction

    function automatic logic [31:0] readVal(input logic [4:0] a);
        logic [31:0] v;
        if (a == 5'd0) return 32'h0;
        v = mRf[a];
        for (int i = 0; i < NUM_WB; i++) if (wb_valid[i] && wb_rd_addr[i*5 +: 5] == a) v = wb_data[i*32 +: 32];
        return v;
    endfunction

    function automatic logic srcBlocked(input logic en, input logic [4:0] a);
        return en && (a != 5'd0) && (mPend[a] > 1 || (mPend[a] == 1 && hits(a) == 0));
    endfunction

    function automatic logic anyBlocked();
        logic rdFull;
        rdFull = bus.in_rd_en && (bus.in_rd_addr != 5'd0) &&
                 (mPend[bus.in_rd_addr] == MAX_PEND) && (hits(bus.in_rd_addr) == 0);
        return srcBlocked(bus.in_rs1_en, bus.in_rs1_addr) ||
               srcBlocked(bus.in_rs2_en, bus.in_rs2_addr) || rdFull;
    endfunction

    // Apply one clock edge to the reference state using the current inputs.
    task automatic modelCommit();
        logic        blocked, slot, acc, kill;
        logic [31:0] v1, v2;
        int          net;
        blocked = anyBlocked();
        slot    = !mOutValid || bus.out_ready;
        acc     = bus.in_valid && slot && !blocked && !flush;
        kill    = flush && mOutValid && !bus.out_ready && mOutRdEn && (mOutRd != 5'd0);
        v1      = readVal(bus.in_rs1_addr);
        v2      = readVal(bus.in_rs2_addr);
        if (bus.in_valid && !flush && slot && blocked && mStall != 32'hFFFFFFFF) mStall = mStall + 1;
        for (int r = 1; r < 32; r++) begin
            net = mPend[r] - hits(5'(r));
            if (acc && bus.in_rd_en && bus.in_rd_addr == 5'(r)) net = net + 1;
            if (kill && mOutRd == 5'(r)) net = net - 1;
            if (net < 0) begin
                net  = 0;
                mErr = 1'b1;
            end
            mPend[r] = net;
        end
        for (int i = 0; i < NUM_WB; i++)
            if (wb_valid[i] && wb_rd_addr[i*5 +: 5] != 5'd0) mRf[wb_rd_addr[i*5 +: 5]] = wb_data[i*32 +: 32];
        if (acc) begin
            mOutValid = 1'b1; mOut1 = v1; mOut2 = v2; mOutRd = bus.in_rd_addr;
            mOutRdEn = bus.in_rd_en; mOutPay = bus.in_payload;
        end else if (flush || bus.out_ready) begin
            mOutValid = 1'b0;
        end
    endtask

    // Stimulus helpers (drive only).
    task automatic setIn(input logic v, input logic e1, input logic [4:0] a1, input logic e2,
                         input logic [4:0] a2, input logic ed, input logic [4:0] ad, input logic [63:0] pay);
        bus.in_valid = v; bus.in_rs1_en = e1; bus.in_rs1_addr = a1; bus.in_rs2_en = e2;
        bus.in_rs2_addr = a2; bus.in_rd_en = ed; bus.in_rd_addr = ad; bus.in_payload = pay;
    endtask

    task automatic setWb(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [31:0] d1);
        wb_valid = {v1, v0}; wb_rd_addr = {a1, a0}; wb_data = {d1, d0};
    endtask

    task automatic toNeg();
        @(negedge clk);
        mReady = !(mOutValid && !bus.out_ready) && !anyBlocked() && !flush;
    endtask

    task automatic toPost();
        modelCommit();
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        flush = 1'b0;
        bus.out_ready = 1'b1;
        setIn(0, 0, 0, 0, 0, 0, 0, 64'h0);
        setWb(0, 0, 0, 0, 0, 0);
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        applyReset();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %0b want 0", bus.out_valid); end
        checks++; if (bus.out_rs1_data !== 32'h0 || bus.out_rs2_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_out_data got %h/%h want 0", bus.out_rs1_data, bus.out_rs2_data); end
        checks++; if (bus.out_payload !== 64'h0 || bus.out_rd_addr !== 5'd0 || bus.out_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_fields got %h/%0d/%0b want 0", bus.out_payload, bus.out_rd_addr, bus.out_rd_en); end
        checks++; if (hazard_stall_cnt !== 32'h0) begin errors++; $display("[TB] FAIL reset_stall_cnt got %0d want 0", hazard_stall_cnt); end
        checks++; if (sb_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_sb_err got %0b want 0", sb_err); end
    endtask

    task automatic test_sp_read();
        setIn(1, 1, 5'd2, 0, 5'd0, 0, 5'd0, 64'h1234_5678_9ABC_DEF0);
        toNeg();
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL sp_in_ready got %0b want 1", bus.in_ready); end
        toPost();
        setIn(0, 0, 0, 0, 0, 0, 0, 64'h0);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL sp_out_valid got %0b want 1", bus.out_valid); end
        checks++; if (bus.out_rs1_data !== 32'h80000000) begin errors++; $display("[TB] FAIL sp_rs1_data got %h want 80000000", bus.out_rs1_data); end
        checks++; if (bus.out_payload !== 64'h1234_5678_9ABC_DEF0) begin errors++; $display("[TB] FAIL sp_payload got %h want 123456789abcdef0", bus.out_payload); end
        toNeg(); toPost();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL sp_drain got %0b want 0", bus.out_valid); end
    endtask

    task automatic test_raw_hazard();
        logic [31:0] base;
        setIn(1, 0, 0, 0, 0, 1, 5'd5, 64'h5);
        toNeg(); toPost();
        setIn(1, 1, 5'd5, 0, 0, 0, 0, 64'h55);
        base = mStall;
        for (int k = 0; k < 3; k++) begin
            toNeg();
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL raw_stall_ready cyc%0d got %0b want 0", k, bus.in_ready); end
            toPost();
        end
        checks++; if (hazard_stall_cnt !== base + 32'd3) begin errors++; $display("[TB] FAIL raw_stall_cnt got %0d want %0d", hazard_stall_cnt, base + 32'd3); end
        setWb(0, 0, 0, 1, 5'd5, 32'h0000DEAD);
        toNeg();
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL raw_wb_ready got %0b want 1", bus.in_ready); end
        toPost();
        setWb(0, 0, 0, 0, 0, 0);
        setIn(0, 0, 0, 0, 0, 0, 0, 64'h0);
        checks++; if (bus.out_rs1_data !== 32'h0000DEAD) begin errors++; $display("[TB] FAIL raw_bypass got %h want 0000dead", bus.out_rs1_data); end
        toNeg(); toPost();
    endtask

    task automatic test_dual_wb();
        setIn(1, 0, 0, 0, 0, 1, 5'd7, 64'h7);
        toNeg(); toPost();
        toNeg(); toPost();
        setIn(0, 0, 0, 0, 0, 0, 0, 64'h0);
        setWb(1, 5'd7, 32'h1, 1, 5'd7, 32'h2);
        toNeg(); toPost();
        setWb(0, 0, 0, 0, 0, 0);
        setIn(1, 1, 5'd7, 1, 5'd7, 0, 0, 64'h77);
        toNeg();
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL dual_ready got %0b want 1", bus.in_ready); end
        toPost();
        setIn(0, 0, 0, 0, 0, 0, 0, 64'h0);
        checks++; if (bus.out_rs1_data !== 32'h2 || bus.out_rs2_data !== 32'h2) begin errors++; $display("[TB] FAIL dual_x7 got %h/%h want 2", bus.out_rs1_data, bus.out_rs2_data); end
        checks++; if (sb_err !== 1'b0) begin errors++; $display("[TB] FAIL dual_sb_err got %0b want 0", sb_err); end
        toNeg(); toPost();
    endtask

    task automatic test_max_pend();
        logic expReady [3] = '{1'b0, 1'b0, 1'b1};
        setIn(1, 0, 0, 0, 0, 1, 5'd9, 64'h9);
        for (int k = 0; k < 3; k++) begin toNeg(); toPost(); end
        for (int k = 0; k < 2; k++) begin
            toNeg();
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL maxp_writer_stall cyc%0d got %0b want 0", k, bus.in_ready); end
            toPost();
        end
        setWb(1, 5'd9, 32'hA0, 0, 0, 0);
        toNeg();
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL maxp_writer_go got %0b want 1", bus.in_ready); end
        toPost();
        setIn(1, 1, 5'd9, 0, 0, 0, 0, 64'h99);
        for (int k = 0; k < 3; k++) begin
            setWb(1, 5'd9, 32'hB0 + 32'(k), 0, 0, 0);
            toNeg();
            checks++; if (bus.in_ready !== expReady[k]) begin errors++; $display("[TB] FAIL maxp_reader cyc%0d got %0b want %0b", k, bus.in_ready, expReady[k]); end
            toPost();
        end
        setWb(0, 0, 0, 0, 0, 0);
        setIn(0, 0, 0, 0, 0, 0, 0, 64'h0);
        checks++; if (bus.out_rs1_data !== 32'hB2) begin errors++; $display("[TB] FAIL maxp_reader_data got %h want b2", bus.out_rs1_data); end
        toNeg(); toPost();
    endtask

    task automatic test_flush();
        applyReset();
        bus.out_ready = 1'b0;
        setIn(1, 0, 0, 0, 0, 1, 5'd4, 64'h4);
        toNeg(); toPost();
        setIn(0, 0, 0, 0, 0, 0, 0, 64'h0);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_rd_addr !== 5'd4) begin errors++; $display("[TB] FAIL flush_held got %0b/%0d want 1/4", bus.out_valid, bus.out_rd_addr); end
        flush = 1'b1;
        setIn(1, 0, 0, 0, 0, 0, 0, 64'h44);
        toNeg();
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_blocks got %0b want 0", bus.in_ready); end
        toPost();
        flush = 1'b0;
        setIn(0, 0, 0, 0, 0, 0, 0, 64'h0);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_kill got %0b want 0", bus.out_valid); end
        checks++; if (sb_err !== 1'b0) begin errors++; $display("[TB] FAIL flush_no_err got %0b want 0", sb_err); end
        setWb(1, 5'd4, 32'h44, 0, 0, 0);
        toNeg(); toPost();
        setWb(0, 0, 0, 0, 0, 0);
        checks++; if (sb_err !== 1'b1) begin errors++; $display("[TB] FAIL flush_underflow got %0b want 1", sb_err); end
        bus.out_ready = 1'b1;
    endtask

    task automatic test_backpressure();
        logic [31:0] base;
        bus.out_ready = 1'b0;
        setIn(1, 1, 5'd2, 0, 0, 0, 0, 64'hAAAA);
        toNeg(); toPost();
        setIn(1, 1, 5'd3, 1, 5'd1, 1, 5'd10, 64'hBBBB);
        base = mStall;
        for (int k = 0; k < 5; k++) begin
            toNeg();
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready cyc%0d got %0b want 0", k, bus.in_ready); end
            toPost();
            checks++; if (bus.out_valid !== 1'b1 || bus.out_payload !== 64'hAAAA || bus.out_rs1_data !== 32'h80000000)
                begin errors++; $display("[TB] FAIL bp_stable cyc%0d got %0b/%h/%h want 1/aaaa/80000000", k, bus.out_valid, bus.out_payload, bus.out_rs1_data); end
        end
        checks++; if (hazard_stall_cnt !== base) begin errors++; $display("[TB] FAIL bp_stall_cnt got %0d want %0d", hazard_stall_cnt, base); end
        bus.out_ready = 1'b1;
        toNeg(); toPost();
        setIn(0, 0, 0, 0, 0, 0, 0, 64'h0);
        checks++; if (bus.out_payload !== 64'hBBBB || bus.out_rd_addr !== 5'd10) begin errors++; $display("[TB] FAIL bp_next got %h/%0d want bbbb/10", bus.out_payload, bus.out_rd_addr); end
        toNeg(); toPost();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            setIn($urandom_range(0, 9) < 7, 1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom),
                  5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)), {$urandom, $urandom});
            bus.out_ready = $urandom_range(0, 9) < 7;
            flush = $urandom_range(0, 19) == 0;
            setWb($urandom_range(0, 9) < 3, 5'($urandom_range(1, 7)), $urandom,
                  $urandom_range(0, 9) < 3, 5'($urandom_range(1, 7)), $urandom);
            toNeg();
            checks++; if (bus.in_ready !== mReady) begin errors++; $display("[TB] FAIL rnd_ready n%0d got %0b want %0b", n, bus.in_ready, mReady); end
            toPost();
            checks++; if (bus.out_valid !== mOutValid) begin errors++; $display("[TB] FAIL rnd_valid n%0d got %0b want %0b", n, bus.out_valid, mOutValid); end
            checks++; if (bus.out_rs1_data !== mOut1 || bus.out_rs2_data !== mOut2) begin errors++; $display("[TB] FAIL rnd_data n%0d got %h/%h want %h/%h", n, bus.out_rs1_data, bus.out_rs2_data, mOut1, mOut2); end
            checks++; if (bus.out_rd_addr !== mOutRd || bus.out_rd_en !== mOutRdEn || bus.out_payload !== mOutPay) begin errors++; $display("[TB] FAIL rnd_fields n%0d got %0d/%0b/%h want %0d/%0b/%h", n, bus.out_rd_addr, bus.out_rd_en, bus.out_payload, mOutRd, mOutRdEn, mOutPay); end
            checks++; if (hazard_stall_cnt !== mStall || sb_err !== mErr) begin errors++; $display("[TB] FAIL rnd_status n%0d got %0d/%0b want %0d/%0b", n, hazard_stall_cnt, sb_err, mStall, mErr); end
        end
        flush = 1'b0;
        bus.out_ready = 1'b1;
        setWb(0, 0, 0, 0, 0, 0);
        setIn(0, 0, 0, 0, 0, 0, 0, 64'h0);
        toNeg(); toPost();
    endtask

    task automatic test_mid_reset();
        applyReset();
        bus.out_ready = 1'b0;
        setIn(1, 0, 0, 0, 0, 1, 5'd6, 64'h66);
        toNeg(); toPost();
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.out_payload !== 64'h0) begin errors++; $display("[TB] FAIL midrst_async got %0b/%h want 0/0", bus.out_valid, bus.out_payload); end
        setIn(0, 0, 0, 0, 0, 0, 0, 64'h0);
        modelReset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        setIn(1, 1, 5'd6, 0, 0, 0, 0, 64'h67);
        toNeg();
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_no_pend got %0b want 1", bus.in_ready); end
        toPost();
        setIn(0, 0, 0, 0, 0, 0, 0, 64'h0);
        setWb(0, 0, 0, 1, 5'd6, 32'h6);
        toNeg(); toPost();
        setWb(0, 0, 0, 0, 0, 0);
        checks++; if (sb_err !== 1'b1) begin errors++; $display("[TB] FAIL midrst_underflow got %0b want 1", sb_err); end
    endtask

    initial begin
        test_reset();
        test_sp_read();
        test_raw_hazard();
        test_dual_wb();
        test_max_pend();
        test_flush();
        test_backpressure();
        test_random();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
